// File: rtl/rs232_sdram_loader_if.sv
// Bus bundle between the RS-232 SDRAM loader (master) and the UART / SDRAM
// Avalon-MM slaves it talks to.
interface rs232_sdram_loader_if #(
    parameter int ADDR_W = 23
);
    logic [2:0]        o_uart_address;
    logic              o_uart_begintransfer;
    logic              o_uart_chipselect;
    logic              o_uart_read_n;
    logic              o_uart_write_n;
    logic [15:0]       o_uart_writedata;
    logic [15:0]       i_uart_readdata;
    logic              i_uart_dataavailable;

    logic [ADDR_W-1:0] o_sdram_address;
    logic [3:0]        o_sdram_byteenable_n;
    logic              o_sdram_chipselect;
    logic [31:0]       o_sdram_writedata;
    logic              o_sdram_read_n;
    logic              o_sdram_write_n;
    logic              i_sdram_waitrequest;

    modport master (
        output o_uart_address, o_uart_begintransfer, o_uart_chipselect,
               o_uart_read_n, o_uart_write_n, o_uart_writedata,
               o_sdram_address, o_sdram_byteenable_n, o_sdram_chipselect,
               o_sdram_writedata, o_sdram_read_n, o_sdram_write_n,
        input  i_uart_readdata, i_uart_dataavailable, i_sdram_waitrequest
    );

    modport slave (
        input  o_uart_address, o_uart_begintransfer, o_uart_chipselect,
               o_uart_read_n, o_uart_write_n, o_uart_writedata,
               o_sdram_address, o_sdram_byteenable_n, o_sdram_chipselect,
               o_sdram_writedata, o_sdram_read_n, o_sdram_write_n,
        output i_uart_readdata, i_uart_dataavailable, i_sdram_waitrequest
    );
endinterface

// File: rtl/rs232_sdram_loader.sv
// Drains received UART bytes, packs them little-endian into 32-bit words and
// writes the words to consecutive SDRAM word addresses.
module rs232_sdram_loader #(
    parameter int ADDR_W      = 23,
    parameter int UART_RD_CYC = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_num_words,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_words_written,
    rs232_sdram_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, WAIT_RX, RD_RX, WR_SD, DONE} state_t;

    localparam logic [2:0] RD_LAST = 3'(UART_RD_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] cnt_inc;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        unused_readdata_hi;

    assign unused_readdata_hi = bus.i_uart_readdata[15:8];
    assign cnt_inc            = cnt_q + ADDR_W'(1);
    assign o_words_written    = cnt_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            rd_cnt_q   <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            rd_cnt_q   <= rd_cnt_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        rd_cnt_d   = rd_cnt_q;
        word_d     = word_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    base_d     = i_base_addr;
                    num_d      = i_num_words;
                    cnt_d      = '0;
                    byte_idx_d = '0;
                    rd_cnt_d   = '0;
                    word_d     = '0;
                    state_d    = (i_num_words == '0) ? DONE : WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (bus.i_uart_dataavailable) state_d = RD_RX;
            end
            RD_RX: begin
                // readdata is only trusted in the final cycle of the held read
                if (rd_cnt_q == RD_LAST) begin
                    rd_cnt_d = '0;
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus.i_uart_readdata[7:0];
                    if (byte_idx_q == 2'd3) begin
                        state_d = WR_SD;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = WAIT_RX;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            WR_SD: begin
                if (!bus.i_sdram_waitrequest) begin
                    cnt_d      = cnt_inc;
                    byte_idx_d = '0;
                    state_d    = (cnt_inc == num_q) ? DONE : WAIT_RX;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort wins over every transition; a partially packed word is dropped
        if (i_abort) begin
            state_d  = IDLE;
            rd_cnt_d = '0;
        end
    end

    always_comb begin
        o_busy                   = (state_q != IDLE) && (state_q != DONE);
        o_done                   = (state_q == DONE);
        bus.o_uart_address       = 3'd0;
        bus.o_uart_chipselect    = (state_q == RD_RX);
        bus.o_uart_read_n        = (state_q != RD_RX);
        bus.o_uart_begintransfer = (state_q == RD_RX) && (rd_cnt_q == 3'd0);
        bus.o_uart_write_n       = 1'b1;
        bus.o_uart_writedata     = 16'd0;
        bus.o_sdram_address      = base_q + cnt_q;
        bus.o_sdram_byteenable_n = 4'b0000;
        bus.o_sdram_chipselect   = (state_q == WR_SD);
        bus.o_sdram_writedata    = word_q;
        bus.o_sdram_read_n       = 1'b1;
        bus.o_sdram_write_n      = (state_q != WR_SD);
    end
endmodule

// File: tb/tb_rs232_sdram_loader.sv
// Self-checking bench: behavioural UART byte source and SDRAM write sink,
// with expected writes computed from the byte stream.
module tb_rs232_sdram_loader;
    localparam int ADDR_W      = 23;
    localparam int UART_RD_CYC = 2;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              i_start;
    logic              i_abort;
    logic [ADDR_W-1:0] i_base_addr;
    logic [ADDR_W-1:0] i_num_words;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_words_written;

    rs232_sdram_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rs232_sdram_loader #(.ADDR_W(ADDR_W), .UART_RD_CYC(UART_RD_CYC)) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_base_addr     (i_base_addr),
        .i_num_words     (i_num_words),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_words_written (o_words_written),
        .bus             (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;

    // UART source state
    logic [7:0] uart_q[$];
    int  gap_cfg  = 0;
    bit  gap_rand = 1'b0;
    int  gap_cnt  = 0;
    bit  cs_prev  = 1'b0;
    bit  bt_prev  = 1'b0;
    int  bt_pulses = 0;
    int  bt_wide   = 0;
    int  uart_cs_cycles = 0;

    // SDRAM sink state
    int                stall_cfg  = 0;
    int                stall_left = 0;
    bit                in_write   = 1'b0;
    logic [ADDR_W-1:0] hold_a;
    logic [31:0]       hold_d;
    int                unstable   = 0;
    int                wr_cycles  = 0;
    logic [ADDR_W-1:0] wr_a[$];
    logic [31:0]       wr_d[$];

    initial begin
        bus.i_uart_readdata      = '0;
        bus.i_uart_dataavailable = 1'b0;
        bus.i_sdram_waitrequest  = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (bus.o_uart_begintransfer) begin
                bt_pulses++;
                if (bt_prev) bt_wide++;
            end
            bt_prev = bus.o_uart_begintransfer;
            if (bus.o_uart_chipselect) uart_cs_cycles++;
            if (cs_prev && !bus.o_uart_chipselect) begin
                if (uart_q.size() > 0) void'(uart_q.pop_front());
                gap_cnt = gap_rand ? int'($urandom_range(0, 4)) : gap_cfg;
            end
            cs_prev = bus.o_uart_chipselect;
            if (gap_cnt > 0) gap_cnt--;
            bus.i_uart_dataavailable = (uart_q.size() > 0) && (gap_cnt == 0);
            bus.i_uart_readdata[15:8] = 8'($urandom);
            bus.i_uart_readdata[7:0]  = (uart_q.size() > 0) ? uart_q[0] : 8'($urandom);

            if (bus.o_sdram_chipselect && !bus.o_sdram_write_n) begin
                wr_cycles++;
                if (!in_write) begin
                    in_write   = 1'b1;
                    hold_a     = bus.o_sdram_address;
                    hold_d     = bus.o_sdram_writedata;
                    stall_left = stall_cfg;
                end else if (bus.o_sdram_address !== hold_a || bus.o_sdram_writedata !== hold_d) begin
                    unstable++;
                end
                if (stall_left > 0) begin
                    bus.i_sdram_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus.i_sdram_waitrequest = 1'b0;
                    wr_a.push_back(bus.o_sdram_address);
                    wr_d.push_back(bus.o_sdram_writedata);
                    in_write = 1'b0;
                end
            end else begin
                bus.i_sdram_waitrequest = 1'b0;
                in_write = 1'b0;
            end
        end
    end

    task automatic clear_obs();
        wr_a.delete();
        wr_d.delete();
        bt_pulses      = 0;
        bt_wide        = 0;
        wr_cycles      = 0;
        unstable       = 0;
        uart_cs_cycles = 0;
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] num);
        @(posedge clk_clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_num_words = num;
        @(posedge clk_clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_clk); #1;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_words_written !== '0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b words=%h expected 0 0 0", o_busy, o_done, o_words_written);
        end
        checks++;
        if (bus.o_uart_chipselect !== 1'b0 || bus.o_uart_read_n !== 1'b1 || bus.o_uart_begintransfer !== 1'b0) begin
            failures++;
            $display("FAIL reset_uart: cs=%b rd_n=%b bt=%b expected 0 1 0",
                     bus.o_uart_chipselect, bus.o_uart_read_n, bus.o_uart_begintransfer);
        end
        checks++;
        if (bus.o_sdram_chipselect !== 1'b0 || bus.o_sdram_write_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_sdram_strobes: cs=%b wr_n=%b expected 0 1", bus.o_sdram_chipselect, bus.o_sdram_write_n);
        end
        checks++;
        if (bus.o_sdram_address !== '0 || bus.o_sdram_writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_sdram_bus: addr=%h data=%h expected 0 0", bus.o_sdram_address, bus.o_sdram_writedata);
        end
        checks++;
        if (bus.o_uart_write_n !== 1'b1 || bus.o_sdram_read_n !== 1'b1 || bus.o_sdram_byteenable_n !== 4'b0000 ||
            bus.o_uart_address !== 3'd0 || bus.o_uart_writedata !== 16'd0) begin
            failures++;
            $display("FAIL tieoffs: uart_wr_n=%b sd_rd_n=%b be_n=%b uaddr=%h uwd=%h expected 1 1 0000 0 0000",
                     bus.o_uart_write_n, bus.o_sdram_read_n, bus.o_sdram_byteenable_n,
                     bus.o_uart_address, bus.o_uart_writedata);
        end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        bit ok;
        clear_obs();
        gap_rand = 1'b0;
        gap_cfg  = 5;
        stall_cfg = 0;
        uart_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(23'h000100, 23'd1);
        wait_done(400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_done: done=%b expected 1 within budget", o_done);
        end
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 23'h000100 || wr_d[0] !== 32'h44332211) begin
            failures++;
            $display("FAIL single_write: writes=%0d first=%h/%h expected 1 000100/44332211",
                     wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : '0, (wr_d.size() > 0) ? wr_d[0] : '0);
        end
        checks++;
        if (o_words_written !== 23'd1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_count: words=%0d busy=%b expected 1 0", o_words_written, o_busy);
        end
        checks++;
        if (bt_pulses != 4 || bt_wide != 0 || uart_cs_cycles != 4 * UART_RD_CYC) begin
            failures++;
            $display("FAIL single_begintransfer: pulses=%0d wide=%0d cs_cycles=%0d expected 4 0 %0d",
                     bt_pulses, bt_wide, uart_cs_cycles, 4 * UART_RD_CYC);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [7:0] b[4];
        logic [ADDR_W-1:0] base;
        clear_obs();
        gap_cfg   = 0;
        stall_cfg = 7;
        base = ADDR_W'($urandom);
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            uart_q.push_back(b[i]);
        end
        start_load(base, 23'd1);
        wait_done(400, ok);
        checks++;
        if (!ok || wr_cycles != 8 || unstable != 0) begin
            failures++;
            $display("FAIL stall_hold: done=%b write_cycles=%0d unstable=%0d expected 1 8 0", ok, wr_cycles, unstable);
        end
        checks++;
        if (wr_a.size() != 1 || o_words_written !== 23'd1 ||
            wr_a[0] !== base || wr_d[0] !== {b[3], b[2], b[1], b[0]}) begin
            failures++;
            $display("FAIL stall_write: writes=%0d words=%0d expected 1 1 data %h at %h",
                     wr_a.size(), o_words_written, {b[3], b[2], b[1], b[0]}, base);
        end
        stall_cfg = 0;
    endtask

    task automatic test_wrap();
        bit ok;
        clear_obs();
        gap_cfg = 0;
        for (int i = 0; i < 8; i++) uart_q.push_back(8'(i));
        start_load(23'h7FFFFF, 23'd2);
        wait_done(400, ok);
        checks++;
        if (!ok || wr_a.size() != 2 || o_words_written !== 23'd2) begin
            failures++;
            $display("FAIL wrap_count: done=%b writes=%0d words=%0d expected 1 2 2", ok, wr_a.size(), o_words_written);
        end else begin
            checks++;
            if (wr_a[0] !== 23'h7FFFFF || wr_d[0] !== 32'h03020100 ||
                wr_a[1] !== 23'h000000 || wr_d[1] !== 32'h07060504) begin
                failures++;
                $display("FAIL wrap_writes: got %h/%h %h/%h expected 7fffff/03020100 000000/07060504",
                         wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
            end
        end
    endtask

    task automatic test_zero_and_priority();
        // leave DONE via abort
        @(posedge clk_clk); #1;
        i_abort = 1'b1;
        @(posedge clk_clk); #1;
        i_abort = 1'b0;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_words_written !== 23'd2) begin
            failures++;
            $display("FAIL abort_from_done: done=%b busy=%b words=%0d expected 0 0 2", o_done, o_busy, o_words_written);
        end
        clear_obs();
        start_load(23'h001234, 23'd0);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_words_written !== '0) begin
            failures++;
            $display("FAIL zero_count: done=%b busy=%b words=%0d expected 1 0 0", o_done, o_busy, o_words_written);
        end
        uart_q = '{8'h5A};
        repeat (6) @(posedge clk_clk);
        #1;
        checks++;
        if (uart_cs_cycles != 0 || wr_cycles != 0 || o_done !== 1'b1) begin
            failures++;
            $display("FAIL zero_no_strobes: uart_cs=%0d sdram_wr=%0d done=%b expected 0 0 1",
                     uart_cs_cycles, wr_cycles, o_done);
        end
        uart_q.delete();
        @(posedge clk_clk); #1;
        i_abort     = 1'b1;
        i_start     = 1'b1;
        i_num_words = 23'd1;
        @(posedge clk_clk); #1;
        i_abort = 1'b0;
        i_start = 1'b0;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_start: done=%b busy=%b expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n;
        clear_obs();
        gap_cfg = 10;
        uart_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        start_load(23'h000040, 23'd1);
        ok = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (uart_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_two_bytes: remaining=%0d expected 2 within budget", uart_q.size());
        end
        i_abort = 1'b1;
        @(posedge clk_clk); #1;
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || bus.o_uart_chipselect !== 1'b0 || o_words_written !== '0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b done=%b ucs=%b words=%0d expected 0 0 0 0",
                     o_busy, o_done, bus.o_uart_chipselect, o_words_written);
        end
        uart_q.delete();
        repeat (20) @(posedge clk_clk);
        #1;
        checks++;
        if (wr_a.size() != 0) begin
            failures++;
            $display("FAIL abort_no_write: writes=%0d expected 0", wr_a.size());
        end
        gap_cfg = 1;
        uart_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_load(23'h000041, 23'd1);
        wait_done(400, ok);
        checks++;
        if (!ok || wr_a.size() != 1 || wr_d[0] !== 32'hDDCCBBAA || wr_a[0] !== 23'h000041) begin
            failures++;
            $display("FAIL abort_restart: done=%b writes=%0d data=%h expected 1 1 ddccbbaa at 000041",
                     ok, wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : '0);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        clear_obs();
        gap_cfg   = 0;
        stall_cfg = 20;
        for (int i = 0; i < 4; i++) uart_q.push_back(8'($urandom));
        start_load(23'h000200, 23'd1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_clk); #1;
            if (bus.o_sdram_write_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_write_reached: write_n=%b expected 0 within budget", bus.o_sdram_write_n);
        end
        reset_reset_n = 1'b0;
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        checks++;
        if (bus.o_sdram_write_n !== 1'b1 || bus.o_sdram_chipselect !== 1'b0 ||
            o_words_written !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_write: wr_n=%b cs=%b words=%0d busy=%b done=%b expected 1 0 0 0 0",
                     bus.o_sdram_write_n, bus.o_sdram_chipselect, o_words_written, o_busy, o_done);
        end
        stall_cfg = 0;
        repeat (5) @(posedge clk_clk);
        #1;
        checks++;
        if (wr_a.size() != 0) begin
            failures++;
            $display("FAIL rst_no_write: writes=%0d expected 0", wr_a.size());
        end
    endtask

    task automatic test_random_back_to_back();
        bit ok;
        logic [7:0]        b[$];
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] exp_a;
        logic [31:0]       exp_d;
        int                num;
        gap_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            b.delete();
            base      = ADDR_W'($urandom);
            num       = int'($urandom_range(1, 4));
            stall_cfg = int'($urandom_range(0, 3));
            for (int i = 0; i < 4 * num; i++) begin
                b.push_back(8'($urandom));
                uart_q.push_back(b[i]);
            end
            start_load(base, ADDR_W'(num));
            wait_done(2000, ok);
            checks++;
            if (!ok || wr_a.size() != num || o_words_written !== ADDR_W'(num)) begin
                failures++;
                $display("FAIL rand_count[%0d]: done=%b writes=%0d words=%0d expected 1 %0d %0d",
                         it, ok, wr_a.size(), o_words_written, num, num);
            end else begin
                for (int w = 0; w < num; w++) begin
                    exp_a = base + ADDR_W'(w);
                    exp_d = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
                    checks++;
                    if (wr_a[w] !== exp_a || wr_d[w] !== exp_d) begin
                        failures++;
                        $display("FAIL rand_write[%0d.%0d]: got %h/%h expected %h/%h",
                                 it, w, wr_a[w], wr_d[w], exp_a, exp_d);
                    end
                end
            end
        end
        gap_rand  = 1'b0;
        stall_cfg = 0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_base_addr   = '0;
        i_num_words   = '0;
        test_reset();
        test_single_word();
        test_stall();
        test_wrap();
        test_zero_and_priority();
        test_abort();
        test_reset_mid_write();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
